// File: rtl/trace_regs_loader.sv
// Host-to-core GPR/PC loader: replays a serial word stream (x0..x31, pc) as RF/PC write strobes.
// Optional trailing XOR checksum word is enabled by defining TRACE_REGS_LOADER_CSUM_EN.
module trace_regs_loader #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  output logic             rf_wen,
  output logic [IDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             pc_wen,
  output logic [XLEN-1:0]  pc_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GPR  = 3'd1,
    S_PC   = 3'd2,
    S_CSUM = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rf_wen_q, rf_wen_d;
  logic [IDX_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  logic               pc_wen_q, pc_wen_d;
  logic [XLEN-1:0]    pc_wdata_q, pc_wdata_d;
  logic               err_q, err_d;
`ifdef TRACE_REGS_LOADER_CSUM_EN
  logic [XLEN-1:0]    acc_q, acc_d;
`endif
  logic               hs;

  assign in_ready  = (state_q == S_GPR) || (state_q == S_PC) || (state_q == S_CSUM);
  assign busy      = in_ready;
  assign done      = (state_q == S_FIN);
  assign hs        = in_valid & in_ready;
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pc_wen    = pc_wen_q;
  assign pc_wdata  = pc_wdata_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pc_wen_d   = 1'b0;
    pc_wdata_d = pc_wdata_q;
    err_d      = err_q;
`ifdef TRACE_REGS_LOADER_CSUM_EN
    acc_d      = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_GPR;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef TRACE_REGS_LOADER_CSUM_EN
          acc_d   = '0;
`endif
        end
      end
      S_GPR: begin
        if (hs) begin
`ifdef TRACE_REGS_LOADER_CSUM_EN
          acc_d = acc_q ^ in_data;
`endif
          // x0 is hardwired zero in the core: never written, only checked.
          if (cnt_q == '0) begin
            if (in_data != '0) err_d = 1'b1;
          end else begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = cnt_q;
            rf_wdata_d = in_data;
          end
          if (cnt_q == LAST_IDX) state_d = S_PC;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      S_PC: begin
        if (hs) begin
          pc_wen_d   = 1'b1;
          pc_wdata_d = in_data;
`ifdef TRACE_REGS_LOADER_CSUM_EN
          acc_d      = acc_q ^ in_data;
          state_d    = S_CSUM;
`else
          state_d    = S_FIN;
`endif
        end
      end
      S_CSUM: begin
        if (hs) begin
`ifdef TRACE_REGS_LOADER_CSUM_EN
          if (in_data != acc_q) err_d = 1'b1;
`endif
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_wen_q   <= 1'b0;
      pc_wdata_q <= '0;
      err_q      <= 1'b0;
`ifdef TRACE_REGS_LOADER_CSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pc_wen_q   <= pc_wen_d;
      pc_wdata_q <= pc_wdata_d;
      err_q      <= err_d;
`ifdef TRACE_REGS_LOADER_CSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_trace_regs_loader.sv
// Bench for trace_regs_loader: directed load scenarios with random data, checked each cycle
// against a word-count reference model of the load protocol.
module tb_trace_regs_loader;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int IDX_W = 5;
`ifdef TRACE_REGS_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int TOTAL = NREGS + 1 + (CSUM ? 1 : 0);

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_data;
  logic             rf_wen;
  logic [IDX_W-1:0] rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             pc_wen;
  logic [XLEN-1:0]  pc_wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset block
  always #5 clock = ~clock;

  trace_regs_loader #(.XLEN(XLEN), .NREGS(NREGS), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pc_wen(pc_wen), .pc_wdata(pc_wdata), .busy(busy),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // reference model: phase 0 idle, 1 accepting words, 2 completion cycle
  int               m_phase;
  int               m_k;
  logic [XLEN-1:0]  m_acc;
  logic             e_rf_wen, e_pc_wen, e_err;
  logic [IDX_W-1:0] e_addr;
  logic [XLEN-1:0]  e_data, e_pc;
  logic [XLEN-1:0]  exp_q[$];

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_acc = '0;
    e_rf_wen = 0; e_pc_wen = 0; e_err = 0; e_addr = '0; e_data = '0; e_pc = '0;
  endtask

  task automatic model_update();
    e_rf_wen = 0;
    e_pc_wen = 0;
    if (m_phase == 0) begin
      if (start) begin m_phase = 1; m_k = 0; e_err = 0; m_acc = '0; end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        if (m_k == 0) begin
          if (in_data != 0) e_err = 1;
        end else if (m_k < NREGS) begin
          e_rf_wen = 1; e_addr = IDX_W'(m_k); e_data = in_data;
        end else if (m_k == NREGS) begin
          e_pc_wen = 1; e_pc = in_data;
          if (!CSUM) m_phase = 2;
        end else begin
          if (in_data !== m_acc) e_err = 1;
          m_phase = 2;
        end
        m_acc = m_acc ^ in_data;
        m_k++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("in_ready", XLEN'(in_ready), XLEN'(m_phase == 1));
    check("busy",     XLEN'(busy),     XLEN'(m_phase == 1));
    check("done",     XLEN'(done),     XLEN'(m_phase == 2));
    check("rf_wen",   XLEN'(rf_wen),   XLEN'(e_rf_wen));
    check("rf_waddr", XLEN'(rf_waddr), XLEN'(e_addr));
    check("rf_wdata", rf_wdata,        e_data);
    check("pc_wen",   XLEN'(pc_wen),   XLEN'(e_pc_wen));
    check("pc_wdata", pc_wdata,        e_pc);
    check("err",      XLEN'(err),      XLEN'(e_err));
  endtask

  task automatic cycle();
    @(negedge clock);
    check_all();
    if (reset_n) model_update();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // pat: 0 always valid, 1 toggling, 2 random; spur_at/rst_at: word index or -1
  task automatic run_load(input int pat, input bit nominal, input bit x0_nz,
                          input int spur_at, input int rst_at, input bit bad_csum);
    int i;
    int guard;
    logic [XLEN-1:0] x;
    exp_q.delete();
    x = '0;
    for (int j = 0; j <= NREGS; j++) begin
      if (j == 0) exp_q.push_back(x0_nz ? (nominal ? XLEN'(64'hDEAD) : (rnd64() | 1)) : '0);
      else        exp_q.push_back(nominal ? XLEN'(64'h1000 + j) : rnd64());
      x = x ^ exp_q[j];
    end
    if (CSUM) exp_q.push_back(bad_csum ? (x ^ 1) : x);
    start = 1; in_valid = 0; in_data = rnd64();
    cycle();
    start = 0;
    i = 0; guard = 0;
    while (i < TOTAL && guard < 1000) begin
      case (pat)
        0:       in_valid = 1;
        1:       in_valid = (guard % 2) == 0;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? exp_q[i] : rnd64();
      start   = (i == spur_at);
      if (i == rst_at) begin
        reset_n = 0; in_valid = 0; start = 0;
        #1;
        model_reset();
        check_all();
        cycle(); cycle();
        reset_n = 1;
        cycle();
        return;
      end
      cycle();
      if (in_valid) i++;
      guard++;
    end
    check("stream_bound", XLEN'(guard < 1000), XLEN'(1));
    start = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rnd64();
      cycle();
    end
    in_valid = 0;
  endtask

  initial begin
    reset_n = 0; start = 0; in_valid = 0; in_data = '0;
    model_reset();
    #2;
    check_all();
    cycle(); cycle();
    reset_n = 1;
    cycle();
    // start asserted while idle-with-valid noise is covered inside run_load
    run_load(0, 1'b1, 1'b0, -1, -1, 1'b0);   // nominal
    run_load(0, 1'b1, 1'b1, -1, -1, 1'b0);   // nonzero x0
    run_load(0, 1'b0, 1'b0, -1, -1, 1'b0);   // err clears on next start
    run_load(1, 1'b0, 1'b0, -1, -1, 1'b0);   // toggling valid
    run_load(2, 1'b0, 1'b0, 10, -1, 1'b0);   // spurious start at cnt 10
    run_load(2, 1'b0, 1'b0, -1, 17, 1'b0);   // reset at cnt 17
    run_load(0, 1'b0, 1'b0, -1, -1, 1'b0);   // restart after reset
`ifdef TRACE_REGS_LOADER_CSUM_EN
    run_load(0, 1'b0, 1'b0, -1, -1, 1'b0);   // good checksum
    run_load(2, 1'b0, 1'b0, -1, -1, 1'b1);   // corrupted checksum
    run_load(1, 1'b0, 1'b0, -1, -1, 1'b0);   // err clears
`endif
    for (int r = 0; r < 4; r++)
      run_load(2, 1'b0, 1'($urandom_range(0, 1)), -1, -1, 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
